mdu: RTL and testbench
======================

// Module: mdu
// PURPOSE
//  Iterative multiply/divide unit for the MIPS pipeline EX stage.
//  Consumes the two operands read from the register file (rs -> src_a, rt -> src_b).
//  Executes MULT/MULTU/DIV/DIVU into private HI/LO registers, and services MTHI/MTLO.
//  HI/LO feed MFHI/MFLO forwarding. busy stalls the ID stage while an op is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand, HI and LO width; must be even and >= 4
// PORTS
//  clk     in   1           clock; all state changes on posedge
//  rst     in   1           synchronous, active-high reset
//  start   in   1           launch op; sampled only when busy==0
//  op      in   2           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a   in   DATA_WIDTH  rs operand (multiplicand / dividend)
//  src_b   in   DATA_WIDTH  rt operand (multiplier / divisor)
//  flush   in   1           abort in-flight op (branch/exception squash)
//  we_hi   in   1           MTHI: HI <= wdata
//  we_lo   in   1           MTLO: LO <= wdata
//  wdata   in   DATA_WIDTH  MTHI/MTLO data
//  busy    out  1           op in flight (CALC or FIX)
//  done    out  1           one-cycle pulse: HI/LO just updated by an op
//  hi      out  DATA_WIDTH  HI register (remainder / product upper half)
//  lo      out  DATA_WIDTH  LO register (quotient / product lower half)
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; busy=0; done=0; counter=0. rst has priority over every input.
//  FSM: IDLE -> CALC on start. CALC stays for DATA_WIDTH iterations, then goes to FIX. FIX -> IDLE.
//   busy = (state != IDLE), registered.
//  Edge E0 (start && IDLE): latch op and operands.
//   Signed ops latch |src_a| and |src_b|, plus result-sign flags.
//   Quotient sign = sa^sb. Remainder sign = sa.
//  CALC, edges E1..E_W (W=DATA_WIDTH), one step per edge, counter 0..W-1:
//   MULT*: radix-2 shift-add on a 2W-bit accumulator.
//   DIV*: restoring divide, one quotient bit per edge.
//  FIX, edge E_{W+1}: apply sign fixup (two's-complement negate), write hi/lo, done<=1, state<=IDLE.
//   Total: result visible W+1 edges after the start edge.
//   Next start is accepted at E_{W+2} at the earliest.
//  Multiply: {hi,lo} = full 2W-bit product (signed for MULT, unsigned for MULTU).
//  Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//  Divide by zero (src_b==0): lo = all ones, hi = src_a. Still takes the full W+1 edges.
//  DIV overflow (src_a = most-negative, src_b = -1): lo = most-negative, hi = 0.
//  start while busy: ignored; no queuing.
//  flush: at the next edge, state<=IDLE and busy<=0. hi/lo are unchanged and done stays 0.
//   flush && start in the same cycle while IDLE: start is dropped.
//  we_hi/we_lo: take effect at the edge only when IDLE and start==0.
//   When busy or start==1 the write is dropped; start has priority.
//   we_hi and we_lo may be set together, and both registers take wdata.
//  done is high for exactly one cycle per completed op and is never set by MTHI/MTLO.
//  hi/lo hold their value at all other times. No combinational path from any input to any output.
// TESTING
//  1 reset: assert rst 2 cycles mid-CALC -> busy=0, done=0, hi=lo=0 on next cycle
//  2 MULT 0xFFFFFFFF * 0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; done exactly 33 edges after start
//    MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE
//  3 DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1)
//    DIVU 100 / 7 -> lo=14, hi=2
//  4 DIV 5 / 0 -> lo=0xFFFFFFFF, hi=5
//    DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0
//  5 start pulsed again at E5 while busy -> ignored, first result intact
//    flush at E10 -> busy=0 next cycle, hi/lo keep old values, no done
//  6 MTHI 0x1234 while IDLE -> hi=0x1234 next cycle
//    MTLO while busy -> lo unchanged
//    MTLO together with start -> write dropped, op runs

Source files
------------

// File: rtl/mdu.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, followed by one sign-fixup cycle that writes HI/LO.
module mdu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  input  logic                  flush_i,
  input  logic                  we_hi_i,
  input  logic                  we_lo_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO accepted
  // CALC  | one multiply or divide step per cycle, DATA_WIDTH cycles
  // FIX   | sign fixup, HI/LO write, done pulse

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic           is_div_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic           div0_q;
  logic [W-1:0]   opnd_q;
  logic [2*W-1:0] acc_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;

  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     rem_ext;
  logic [W:0]     div_diff;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quot_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    signed_op = ~op_i[0];
    a_neg     = signed_op & src_a_i[W-1];
    b_neg     = signed_op & src_b_i[W-1];
    a_mag     = a_neg ? -src_a_i : src_a_i;
    b_mag     = b_neg ? -src_b_i : src_b_i;

    // Multiply: acc = {partial product, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + ({1'b0, opnd_q} & {(W+1){acc_q[0]}});
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    rem_ext  = acc_q[2*W-1:W-1];
    div_diff = rem_ext - {1'b0, opnd_q};
    if (div_diff[W]) begin
      div_next = {rem_ext[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end

    // A zero divisor leaves remainder = |dividend|, so only the quotient is forced
    prod_fix = q_neg_q ? -acc_q : acc_q;
    quot_fix = div0_q ? '1 : (q_neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]);
    rem_fix  = r_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op_i[1];
            q_neg_q  <= a_neg ^ b_neg;
            r_neg_q  <= a_neg;
            div0_q   <= op_i[1] && (src_b_i == '0);
            if (op_i[1]) begin
              acc_q  <= {{W{1'b0}}, a_mag};
              opnd_q <= b_mag;
            end else begin
              acc_q  <= {{W{1'b0}}, b_mag};
              opnd_q <= a_mag;
            end
          end else if (!start_i) begin
            if (we_hi_i) hi_q <= wdata_i;
            if (we_lo_i) lo_q <= wdata_i;
          end
        end
        S_CALC: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (flush_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vector table, hand-written control
// sequences (reset, restart, flush, MTHI/MTLO) and random ops against a reference model.
module tb_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst, start, flush, we_hi, we_lo;
  logic [1:0]    op;
  logic [W-1:0]  src_a, src_b, wdata;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu #(.DATA_WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .flush_i (flush),
    .we_hi_i (we_hi),
    .we_lo_i (we_lo),
    .wdata_i (wdata),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: returns {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    int q, r;
    case (o)
      2'b00: begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
      end
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int n;
    launch(o, a, b);
    chk({name, "_busy"}, busy, 1);
    wait_done(0, n);
    chk({name, "_latency"}, n, 33);
    chk({name, "_hi"}, hi, exp[63:32]);
    chk({name, "_lo"}, lo, exp[31:0]);
    chk({name, "_busy_end"}, busy, 0);
    tick();
    chk({name, "_done_pulse"}, done, 0);
  endtask

  vec_t vecs [9];

  initial begin
    int n, dcount, sel;
    logic [31:0] ph, pl, ra, rb;
    logic [1:0]  ro;

    vecs[0] = '{"mult_neg",   2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{"multu",      2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{"div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_100_7", 2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{"div_by0",    2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6] = '{"mult_min2",  2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[7] = '{"div_7_m2",   2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{"divu_by0",   2'b11, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst = 1'b1; start = 1'b0; flush = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; wdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // Reset asserted mid-CALC
    launch(2'b01, 32'd1234, 32'd5678);
    repeat (5) tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("midcalc_rst_busy", busy, 0);
    chk("midcalc_rst_done", done, 0);
    chk("midcalc_rst_hi", hi, 0);
    chk("midcalc_rst_lo", lo, 0);
    dcount = 0;
    repeat (40) begin tick(); if (done) dcount++; end
    chk("midcalc_rst_no_done", dcount, 0);

    // Second start at E5 is ignored
    launch(2'b11, 32'd100, 32'd7);
    repeat (4) tick();
    op = 2'b01; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, n);
    chk("restart_latency", n, 33);
    chk("restart_hi", hi, 2);
    chk("restart_lo", lo, 14);
    tick();

    // Flush at E10
    launch(2'b00, 32'd3, 32'd5);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    dcount = 0;
    repeat (40) begin tick(); if (done) dcount++; end
    chk("flush_no_done", dcount, 0);
    chk("flush_hi", hi, 2);
    chk("flush_lo", lo, 14);

    // flush together with start while idle drops the start
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", busy, 0);

    // MTHI / MTLO
    wdata = 32'h1234; we_hi = 1'b1;
    tick();
    we_hi = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo_kept", lo, 14);
    chk("mthi_no_done", done, 0);
    wdata = 32'h5A5A_0F0F; we_hi = 1'b1; we_lo = 1'b1;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
    chk("mt_both_hi", hi, 32'h5A5A_0F0F);
    chk("mt_both_lo", lo, 32'h5A5A_0F0F);

    launch(2'b11, 32'd100, 32'd7);
    repeat (3) tick();
    wdata = 32'h5555; we_lo = 1'b1;
    tick();
    we_lo = 1'b0;
    chk("mtlo_busy_lo", lo, 32'h5A5A_0F0F);
    wait_done(4, n);
    chk("mtlo_busy_res_lo", lo, 14);
    tick();

    op = 2'b01; src_a = 32'd6; src_b = 32'd7; start = 1'b1; wdata = 32'hAAAA; we_lo = 1'b1;
    tick();
    start = 1'b0; we_lo = 1'b0;
    chk("mtlo_start_lo", lo, 14);
    chk("mtlo_start_busy", busy, 1);
    wait_done(0, n);
    chk("mtlo_start_res_hi", hi, 0);
    chk("mtlo_start_res_lo", lo, 42);
    tick();

    // Random operations against the reference model
    for (int k = 0; k < 60; k++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 15));
        4: rb = -32'($urandom_range(1, 15));
        default: ;
      endcase
      {ph, pl} = model(ro, ra, rb);
      run_op("rand", ro, ra, rb, {ph, pl});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
